// File: rtl/hex_display_pkg.sv
// Shared constants for the multi-digit seven-segment display controller.
package hex_display_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned SEG_W  = 7;

  // Per-digit display mode, two bits per digit in the MODE register.
  typedef enum logic [1:0] {
    MODE_HEX   = 2'b00,
    MODE_RAW   = 2'b01,
    MODE_BLANK = 2'b10,
    MODE_BLINK = 2'b11
  } mode_e;

  // Word addresses of the register map.
  localparam logic [ADDR_W-1:0] ADDR_VALUE    = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_MODE     = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_CTRL     = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_RAW_BASE = 4'd4;

  // CTRL register layout, LSB first: enable, lzs, phase, restart.
  typedef struct packed {
    logic restart;
    logic phase;
    logic lzs;
    logic enable;
  } ctrl_t;

  // Nibble to segments, active-high, bit 0 = a ... bit 6 = g.
  localparam logic [15:0][SEG_W-1:0] SEG7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex_display_mm_if.sv
// Avalon-MM slave port of the display controller.
interface hex_display_mm_if;
  import hex_display_pkg::*;

  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_readdatavalid;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg7_decode
  import hex_display_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = SEG7_TABLE[nibble];

endmodule

// File: rtl/hex_display_mm.sv
// Multi-digit seven-segment controller: register file, blink timer,
// leading-zero suppression and registered segment outputs.
module hex_display_mm
  import hex_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned BLINK_DIV  = 25_000_000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  hex_display_mm_if.slave             avs,
  output logic [SEG_W*NUM_DIGITS-1:0] hex_out
);

  localparam int unsigned HEX_W  = SEG_W * NUM_DIGITS;
  localparam int unsigned MODE_W = 2 * NUM_DIGITS;
  localparam int unsigned CNT_W  = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
  localparam logic [HEX_W-1:0] HEX_OFF  = {HEX_W{ACTIVE_LOW}};

  logic [DATA_W-1:0] value_q;
  logic [MODE_W-1:0] mode_q;
  logic [SEG_W-1:0]  raw_q [NUM_DIGITS];
  logic              enable_q;
  logic              lzs_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              phase_q;

  logic                  wr_value_c;
  logic                  wr_mode_c;
  logic                  wr_ctrl_c;
  logic                  restart_c;
  logic [NUM_DIGITS-1:0] wr_raw_c;
  logic [NUM_DIGITS-1:0] hexlike_c;
  logic [NUM_DIGITS-1:0] suppress_c;
  logic [SEG_W-1:0]      dec_c [NUM_DIGITS];
  logic [HEX_W-1:0]      hex_next_c;
  logic [DATA_W-1:0]     rdata_c;
  ctrl_t                 ctrl_rd_c;

  // Write address decode.
  always_comb begin
    wr_value_c = avs.avs_write && (avs.avs_address == ADDR_VALUE);
    wr_mode_c  = avs.avs_write && (avs.avs_address == ADDR_MODE);
    wr_ctrl_c  = avs.avs_write && (avs.avs_address == ADDR_CTRL);
    restart_c  = wr_ctrl_c && avs.avs_writedata[3];
    wr_raw_c   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      wr_raw_c[i] = avs.avs_write && (avs.avs_address == ADDR_W'(ADDR_RAW_BASE + i));
    end
  end

  // Register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q  <= '0;
      mode_q   <= '0;
      enable_q <= 1'b1;
      lzs_q    <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) raw_q[i] <= '0;
    end else begin
      if (wr_value_c) value_q <= avs.avs_writedata;
      if (wr_mode_c)  mode_q  <= avs.avs_writedata[MODE_W-1:0];
      if (wr_ctrl_c) begin
        enable_q <= avs.avs_writedata[0];
        lzs_q    <= avs.avs_writedata[1];
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_raw_c[i]) raw_q[i] <= avs.avs_writedata[SEG_W-1:0];
      end
    end
  end

  // Blink prescaler; a restart write takes priority over a wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (restart_c) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // One nibble decoder per digit.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .nibble (value_q[NIB_W*g +: NIB_W]),
      .seg_c  (dec_c[g])
    );
  end

  // Leading-zero suppression: hex/blink digits above the highest nonzero one go dark.
  always_comb begin : p_lzs
    logic seen;
    seen       = 1'b0;
    hexlike_c  = '0;
    suppress_c = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      hexlike_c[i] = (mode_q[2*i +: 2] == MODE_HEX) || (mode_q[2*i +: 2] == MODE_BLINK);
      if (hexlike_c[i] && (value_q[NIB_W*i +: NIB_W] != '0)) seen = 1'b1;
      suppress_c[i] = lzs_q && (i != 0) && hexlike_c[i] && !seen;
    end
  end

  // Per-digit segment selection and output polarity.
  always_comb begin : p_sel
    logic [SEG_W-1:0] seg;
    seg        = '0;
    hex_next_c = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      seg = '0;
      if (enable_q && !suppress_c[i]) begin
        case (mode_e'(mode_q[2*i +: 2]))
          MODE_HEX:   seg = dec_c[i];
          MODE_RAW:   seg = raw_q[i];
          MODE_BLINK: seg = phase_q ? '0 : dec_c[i];
          default:    seg = '0;
        endcase
      end
      hex_next_c[SEG_W*i +: SEG_W] = ACTIVE_LOW ? ~seg : seg;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hex_out <= HEX_OFF;
    else        hex_out <= hex_next_c;
  end

  // Read mux over the pre-write register state.
  always_comb begin
    ctrl_rd_c = '{restart: 1'b0, phase: phase_q, lzs: lzs_q, enable: enable_q};
    rdata_c   = '0;
    if (avs.avs_address == ADDR_VALUE)     rdata_c = value_q;
    else if (avs.avs_address == ADDR_MODE) rdata_c = DATA_W'(mode_q);
    else if (avs.avs_address == ADDR_CTRL) rdata_c = DATA_W'(ctrl_rd_c);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (avs.avs_address == ADDR_W'(ADDR_RAW_BASE + i)) rdata_c = DATA_W'(raw_q[i]);
    end
  end

  // Read response, fixed latency one; data holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avs.avs_readdatavalid <= 1'b0;
      avs.avs_readdata      <= '0;
    end else begin
      avs.avs_readdatavalid <= avs.avs_read;
      if (avs.avs_read) avs.avs_readdata <= rdata_c;
    end
  end

endmodule

// File: tb/tb_hex_display_mm.sv
// Self-checking bench for hex_display_mm: cycle compare against a
// rule-level model plus hand-computed spot checks.
module tb_hex_display_mm;

  localparam int ND = 6;
  localparam int BD = 4;
  localparam int HW = 7 * ND;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic chk_en = 1'b0;
  logic [HW-1:0] hex_out;

  int n_pass = 0;
  int n_total = 0;

  hex_display_mm_if bus ();

  hex_display_mm #(.NUM_DIGITS(ND), .BLINK_DIV(BD), .ACTIVE_LOW(1'b1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .avs     (bus),
    .hex_out (hex_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // ---------------- model ----------------
  logic [31:0]          m_value;
  logic [2*ND-1:0]      m_mode;
  logic [ND-1:0][6:0]   m_raw;
  logic                 m_en;
  logic                 m_lzs;
  int                   m_t;
  logic                 m_phase;
  logic [HW-1:0]        exp_hex;
  logic                 exp_rdv;
  logic [31:0]          exp_rd;

  // Phase is the parity of whole blink half-periods since reset or restart.
  assign m_phase = ((m_t / BD) % 2) != 0;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'h3F; 4'h1: hex_seg = 7'h06; 4'h2: hex_seg = 7'h5B; 4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66; 4'h5: hex_seg = 7'h6D; 4'h6: hex_seg = 7'h7D; 4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F; 4'h9: hex_seg = 7'h6F; 4'hA: hex_seg = 7'h77; 4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39; 4'hD: hex_seg = 7'h5E; 4'hE: hex_seg = 7'h79; default: hex_seg = 7'h71;
    endcase
  endfunction

  function automatic logic [HW-1:0] calc_hex(input logic [31:0] v, input logic [2*ND-1:0] md,
                                             input logic [ND-1:0][6:0] rw, input logic en,
                                             input logic lzs, input logic ph);
    int k;
    logic [1:0] mi;
    logic [6:0] s;
    logic hl;
    k = -1;
    calc_hex = '0;
    for (int i = 0; i < ND; i++) begin
      mi = md[2*i +: 2];
      if ((mi == 2'b00 || mi == 2'b11) && v[4*i +: 4] != 4'h0) k = i;
    end
    for (int i = 0; i < ND; i++) begin
      mi = md[2*i +: 2];
      hl = (mi == 2'b00 || mi == 2'b11);
      s = 7'h00;
      if (en) begin
        if (mi == 2'b01) s = rw[i];
        else if (mi == 2'b00 || (mi == 2'b11 && !ph)) s = hex_seg(v[4*i +: 4]);
        if (hl && lzs && i > k && i != 0) s = 7'h00;
      end
      calc_hex[7*i +: 7] = ~s;
    end
  endfunction

  function automatic logic [31:0] rd_model(input logic [3:0] a);
    rd_model = '0;
    if (a == 4'd0) rd_model = m_value;
    else if (a == 4'd1) rd_model = 32'(m_mode);
    else if (a == 4'd2) rd_model = {29'd0, m_phase, m_lzs, m_en};
    else begin
      for (int i = 0; i < ND; i++) if (a == 4'(4 + i)) rd_model = {25'd0, m_raw[i]};
    end
  endfunction

  // Model state and expected outputs, advanced on the DUT clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_value <= '0; m_mode <= '0; m_raw <= '0; m_en <= 1'b1; m_lzs <= 1'b0; m_t <= 0;
      exp_hex <= '1; exp_rdv <= 1'b0; exp_rd <= '0;
    end else begin
      exp_hex <= calc_hex(m_value, m_mode, m_raw, m_en, m_lzs, m_phase);
      exp_rdv <= bus.avs_read;
      if (bus.avs_read) exp_rd <= rd_model(bus.avs_address);
      if (bus.avs_write && bus.avs_address == 4'd2 && bus.avs_writedata[3]) m_t <= 0;
      else m_t <= m_t + 1;
      if (bus.avs_write) begin
        if (bus.avs_address == 4'd0) m_value <= bus.avs_writedata;
        if (bus.avs_address == 4'd1) m_mode <= bus.avs_writedata[2*ND-1:0];
        if (bus.avs_address == 4'd2) begin
          m_en  <= bus.avs_writedata[0];
          m_lzs <= bus.avs_writedata[1];
        end
        for (int i = 0; i < ND; i++)
          if (bus.avs_address == 4'(4 + i)) m_raw[i] <= bus.avs_writedata[6:0];
      end
    end
  end

  // Cycle compare on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_hex_out", 64'(hex_out), 64'(exp_hex));
      check("cyc_readdatavalid", 64'(bus.avs_readdatavalid), 64'(exp_rdv));
      check("cyc_readdata", 64'(bus.avs_readdata), 64'(exp_rd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1;
    @(posedge clk); #2;
    bus.avs_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus.avs_address = a; bus.avs_read = 1'b1;
    @(posedge clk); #2;
    bus.avs_read = 1'b0;
    check("rd_valid", 64'(bus.avs_readdatavalid), 64'd1);
    d = bus.avs_readdata;
  endtask

  task automatic rdwr(input logic [3:0] a, input logic [31:0] wd, output logic [31:0] d);
    bus.avs_address = a; bus.avs_writedata = wd; bus.avs_read = 1'b1; bus.avs_write = 1'b1;
    @(posedge clk); #2;
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
    d = bus.avs_readdata;
  endtask

  initial begin
    logic [31:0] d;
    bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("reset_hex_off", 64'(hex_out), 64'({HW{1'b1}}));
    check("reset_rdv", 64'(bus.avs_readdatavalid), 64'd0);
    rst_n = 1'b1;
    idle(1);
    check("post_reset_zeros", 64'(hex_out), 64'({6{7'h40}}));

    // Hex decode and read-back.
    wr(4'd0, 32'h00C0FFEE);
    idle(1);
    check("hex_c0ffee", 64'(hex_out), 64'({7'h46, 7'h40, 7'h0E, 7'h0E, 7'h06, 7'h06}));
    rd(4'd0, d);
    check("rd_value", 64'(d), 64'h00C0FFEE);
    idle(1);
    check("rdv_one_cycle", 64'(bus.avs_readdatavalid), 64'd0);

    // Leading-zero suppression.
    wr(4'd2, 32'h3);
    wr(4'd0, 32'h120);
    idle(1);
    check("lzs_120", 64'(hex_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h40}));
    wr(4'd0, 32'h0);
    idle(1);
    check("lzs_zero", 64'(hex_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));

    // Blink on digit 1, then restart mid-period.
    wr(4'd2, 32'h1);
    wr(4'd0, 32'h21);
    wr(4'd1, 32'hC);
    idle(6);
    wr(4'd2, 32'h9);
    rd(4'd2, d);
    check("ctrl_after_restart", 64'(d), 64'h1);
    idle(3);
    check("blink_lit", 64'(hex_out[13:7]), 64'(7'h24));
    rd(4'd2, d);
    check("ctrl_phase1", 64'(d), 64'h5);
    check("blink_dark", 64'(hex_out[13:7]), 64'(7'h7F));
    idle(9);

    // Raw mode and unmapped addresses.
    wr(4'd1, 32'h10);
    wr(4'd6, 32'h49);
    idle(1);
    check("raw_digit2", 64'(hex_out[20:14]), 64'(7'h36));
    wr(4'd3, 32'hFFFF_FFFF);
    wr(4'd10, 32'hFFFF_FFFF);
    wr(4'd15, 32'hFFFF_FFFF);
    idle(2);
    rd(4'd3, d);  check("rd_addr3", 64'(d), 64'd0);
    rd(4'd10, d); check("rd_addr10", 64'(d), 64'd0);
    rd(4'd6, d);  check("rd_raw2", 64'(d), 64'h49);
    rd(4'd0, d);  check("rd_value_kept", 64'(d), 64'h21);
    rd(4'd1, d);  check("rd_mode", 64'(d), 64'h10);

    // Read and write in the same cycle.
    rdwr(4'd0, 32'hDEADBEEF, d);
    check("rdwr_old", 64'(d), 64'h21);
    rd(4'd0, d);
    check("rdwr_new", 64'(d), 64'hDEADBEEF);

    // Reset while a read response is pending.
    bus.avs_address = 4'd0; bus.avs_read = 1'b1;
    @(posedge clk); #2;
    bus.avs_read = 1'b0;
    check("pend_rdv", 64'(bus.avs_readdatavalid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_drop_rdv", 64'(bus.avs_readdatavalid), 64'd0);
    check("rst_readdata", 64'(bus.avs_readdata), 64'd0);
    check("rst_hex_off", 64'(hex_out), 64'({HW{1'b1}}));
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle(1);
    check("rerelease_zeros", 64'(hex_out), 64'({6{7'h40}}));
    rd(4'd0, d);
    check("rd_after_reset", 64'(d), 64'd0);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
